// File: rtl/regex_stream_ctx.sv
`default_nettype none
// ============================================================================
// Module   : regex_stream_ctx
// Purpose  : Per-stream context manager for an external regex DFA. On each
//            packet start it restores the saved DFA state of the packet's
//            stream. It forwards payload bytes to the DFA with one cycle of
//            delay and waits out the DFA latency after end-of-packet. Then it
//            saves the final DFA state and counts matching packets, but only
//            for packets that have the regex enabled.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          clock / asynchronous active-high reset
//   pkt_start         start-of-packet pulse; samples stream_id and enable
//   stream_id         packet stream id, also the flush target
//   enable            regex enabled for the packet being started
//   char_in/_vld      payload byte and its valid
//   eop               end of packet (with or after the last byte)
//   flush_stream      invalidate the saved context of stream_id
//   count_clr         synchronous clear of count and count_sat
//   dfa_char/_vld     registered byte to the DFA
//   dfa_state_in/_vld state to load into the DFA, one-cycle strobe
//   dfa_state_out     DFA current state
//   dfa_accept        DFA accept flag
//   count, count_sat  saturating match count and its sticky saturation flag
//   fired             current/last packet matched
//   busy              controller not idle
//   proto_err         sticky protocol-violation flag
// ============================================================================
module regex_stream_ctx #(
  parameter int STATE_W = 11,
  parameter int SID_W   = 6,
  parameter int COUNT_W = 16,
  parameter int DFA_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_start,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               flush_stream,
  input  logic               count_clr,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept,
  output logic [COUNT_W-1:0] count,
  output logic               count_sat,
  output logic               fired,
  output logic               busy,
  output logic               proto_err
);

  localparam int                 C_DEPTH      = 1 << SID_W;
  localparam logic [COUNT_W-1:0] C_COUNT_MAX  = '1;
  localparam logic [2:0]         C_DRAIN_LAST = 3'(DFA_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [SID_W-1:0]     r_cur_sid;
  logic                 r_cur_en;
  logic [2:0]           r_drain_cnt;
  logic [STATE_W-1:0]   r_dfa_st;
  logic [C_DEPTH-1:0]   r_valid;
  logic [STATE_W-1:0]   r_state_mem [C_DEPTH];
  logic [COUNT_W-1:0]   r_count;
  logic                 r_count_sat;
  logic                 r_fired;
  logic                 r_proto_err;
  logic [7:0]           r_dfa_char;
  logic                 r_dfa_char_vld;

  logic                 w_commit_en;
  logic                 w_err;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (pkt_start) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_RUN;
      S_RUN:    if (eop) w_state_next = S_DRAIN;
      // DRAIN spans DFA_LAT+1 cycles: the final byte leaves on dfa_char in the
      // first one, and its DFA result is sampled at the end of the last one.
      S_DRAIN:  if (r_drain_cnt == C_DRAIN_LAST) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_commit_en = (r_state == S_COMMIT) && r_cur_en;

  // pkt_start is only meaningful in IDLE. Bytes are only meaningful in RUN.
  // A byte in LOAD is dropped silently.
  assign w_err = (pkt_start && (r_state != S_IDLE)) ||
                 (char_in_vld && ((r_state == S_IDLE) ||
                                  (r_state == S_DRAIN) ||
                                  (r_state == S_COMMIT)));

  // --------------------------------------------------------------------------
  // Context, DFA interface, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_sid      <= '0;
      r_cur_en       <= 1'b0;
      r_drain_cnt    <= '0;
      r_dfa_st       <= '0;
      r_valid        <= '0;
      r_count        <= '0;
      r_count_sat    <= 1'b0;
      r_fired        <= 1'b0;
      r_proto_err    <= 1'b0;
      r_dfa_char     <= '0;
      r_dfa_char_vld <= 1'b0;
    end else begin
      r_dfa_st       <= dfa_state_out;
      r_dfa_char     <= char_in;
      // Covers the eop byte too: it is sampled in RUN and appears during DRAIN.
      r_dfa_char_vld <= (r_state == S_RUN) && char_in_vld;

      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 3'd1;
      end else begin
        r_drain_cnt <= '0;
      end

      if ((r_state == S_IDLE) && pkt_start) begin
        r_cur_sid <= stream_id;
        r_cur_en  <= enable;
        r_fired   <= 1'b0;
      end

      // fired is itself the registered copy of dfa_accept. It is sampled on
      // the same edge as r_dfa_st, so the final byte's result is included by
      // the time COMMIT uses it.
      if (((r_state == S_RUN) || (r_state == S_DRAIN)) && dfa_accept) begin
        r_fired <= 1'b1;
      end

      if ((r_state == S_COMMIT) && !r_cur_en) begin
        r_fired <= 1'b0;
      end

      if ((r_state == S_IDLE) && !pkt_start && flush_stream) begin
        r_valid[stream_id] <= 1'b0;
      end

      if (w_commit_en) begin
        r_valid[r_cur_sid] <= 1'b1;
      end

      if (count_clr) begin
        r_count     <= '0;
        r_count_sat <= 1'b0;
      end else if (w_commit_en && r_fired && (r_count != C_COUNT_MAX)) begin
        r_count <= r_count + 1'b1;
        if ((r_count + 1'b1) == C_COUNT_MAX) begin
          r_count_sat <= 1'b1;
        end
      end

      if (w_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // State storage has no reset; the valid bits decide whether it is read.
  always_ff @(posedge clk) begin
    if (w_commit_en) begin
      r_state_mem[r_cur_sid] <= r_dfa_st;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dfa_char         = r_dfa_char;
  assign dfa_char_vld     = r_dfa_char_vld;
  assign dfa_state_in_vld = (r_state == S_LOAD);
  assign dfa_state_in     = r_valid[r_cur_sid] ? r_state_mem[r_cur_sid] : '0;
  assign count            = r_count;
  assign count_sat        = r_count_sat;
  assign fired            = r_fired;
  assign busy             = (r_state != S_IDLE);
  assign proto_err        = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_regex_stream_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_regex_stream_ctx
// Purpose  : Directed bench for regex_stream_ctx. The DUT is built with
//            COUNT_W=4 so that saturation is reachable. A one-cycle DFA model
//            recognises "abc". Each accepted byte leaves the model in state 3
//            and pulses accept.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regex_stream_ctx;

  localparam int STATE_W = 11;
  localparam int SID_W   = 6;
  localparam int COUNT_W = 4;

  logic               clk;
  logic               rst;
  logic               pkt_start;
  logic [SID_W-1:0]   stream_id;
  logic               enable;
  logic [7:0]         char_in;
  logic               char_in_vld;
  logic               eop;
  logic               flush_stream;
  logic               count_clr;
  logic [7:0]         dfa_char;
  logic               dfa_char_vld;
  logic [STATE_W-1:0] dfa_state_in;
  logic               dfa_state_in_vld;
  logic [STATE_W-1:0] dfa_state_out;
  logic               dfa_accept;
  logic [COUNT_W-1:0] count;
  logic               count_sat;
  logic               fired;
  logic               busy;
  logic               proto_err;

  int n_chk;
  int n_bad;

  regex_stream_ctx #(
    .STATE_W(STATE_W),
    .SID_W  (SID_W),
    .COUNT_W(COUNT_W),
    .DFA_LAT(1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pkt_start       (pkt_start),
    .stream_id       (stream_id),
    .enable          (enable),
    .char_in         (char_in),
    .char_in_vld     (char_in_vld),
    .eop             (eop),
    .flush_stream    (flush_stream),
    .count_clr       (count_clr),
    .dfa_char        (dfa_char),
    .dfa_char_vld    (dfa_char_vld),
    .dfa_state_in    (dfa_state_in),
    .dfa_state_in_vld(dfa_state_in_vld),
    .dfa_state_out   (dfa_state_out),
    .dfa_accept      (dfa_accept),
    .count           (count),
    .count_sat       (count_sat),
    .fired           (fired),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DFA model for the pattern "abc", with a latency of one cycle.
  function automatic logic [STATE_W-1:0] nxt(input logic [STATE_W-1:0] s, input logic [7:0] c);
    if (c == 8'h61) return 11'd1;
    if ((s == 11'd1) && (c == 8'h62)) return 11'd2;
    if ((s == 11'd2) && (c == 8'h63)) return 11'd3;
    return 11'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dfa_state_out <= '0;
      dfa_accept    <= 1'b0;
    end else if (dfa_state_in_vld) begin
      dfa_state_out <= dfa_state_in;
      dfa_accept    <= 1'b0;
    end else if (dfa_char_vld) begin
      dfa_state_out <= nxt(dfa_state_out, dfa_char);
      dfa_accept    <= (nxt(dfa_state_out, dfa_char) == 11'd3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends one packet. The bytes are taken most-significant first from the low
  // len bytes of data. The optional hooks are:
  //   flush_mid  - flush the same stream while its packet is running
  //   stray      - a stray pkt_start in the first DRAIN cycle
  //   clr_commit - assert count_clr during COMMIT
  task automatic send_pkt(input logic [SID_W-1:0] sid, input logic en,
                          input logic [31:0] data, input int len,
                          input logic flush_mid, input logic stray, input logic clr_commit,
                          output logic [STATE_W-1:0] ld_state, output logic ld_vld);
    stream_id = sid;
    enable    = en;
    pkt_start = 1'b1;
    tick;                                   // LOAD
    ld_state  = dfa_state_in;
    ld_vld    = dfa_state_in_vld;
    pkt_start = 1'b0;
    tick;                                   // RUN
    for (int i = 0; i < len; i++) begin
      char_in     = data[8*(len-1-i) +: 8];
      char_in_vld = 1'b1;
      eop         = (i == len-1);
      if (flush_mid && (i == 0)) flush_stream = 1'b1;
      tick;
      flush_stream = 1'b0;
    end
    char_in_vld = 1'b0;
    eop         = 1'b0;
    chk("eop_byte_vld", dfa_char_vld, 1);   // first DRAIN cycle
    chk("eop_byte", dfa_char, data[7:0]);
    if (stray) pkt_start = 1'b1;
    tick;                                   // second DRAIN cycle
    pkt_start = 1'b0;
    chk("dfa_vld_off", dfa_char_vld, 0);
    tick;                                   // COMMIT
    if (clr_commit) count_clr = 1'b1;
    tick;
    count_clr = 1'b0;
    for (int k = 0; (k < 10) && busy; k++) tick;
    chk("back_idle", busy, 0);
  endtask

  logic [STATE_W-1:0] ld;
  logic               lv;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1; pkt_start = 1'b0; stream_id = '0; enable = 1'b0;
    char_in = '0; char_in_vld = 1'b0; eop = 1'b0; flush_stream = 1'b0; count_clr = 1'b0;
    repeat (2) tick;
    chk("rst_count", count, 0);
    chk("rst_sat", count_sat, 0);
    chk("rst_fired", fired, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_dcv", dfa_char_vld, 0);
    chk("rst_dsiv", dfa_state_in_vld, 0);
    rst = 1'b0;
    tick;

    // New stream 5, matching packet.
    send_pkt(5, 1, 32'h78616263, 4, 0, 0, 0, ld, lv);
    chk("new_ld_vld", lv, 1);
    chk("new_ld", ld, 0);
    chk("new_fired", fired, 1);
    chk("new_count", count, 1);
    send_pkt(5, 1, 32'h78, 1, 0, 0, 0, ld, lv);
    chk("s5_restore3", ld, 3);
    chk("s5_nomatch_fired", fired, 0);
    chk("s5_nomatch_count", count, 1);

    // Split match across packets of stream 5, with stream 9 in between.
    send_pkt(5, 1, 32'h6162, 2, 0, 0, 0, ld, lv);
    chk("split1_ld", ld, 0);
    chk("split1_fired", fired, 0);
    send_pkt(9, 1, 32'h7a7a61, 3, 0, 0, 0, ld, lv);
    chk("s9_ld", ld, 0);
    chk("s9_fired", fired, 0);
    send_pkt(5, 1, 32'h63, 1, 0, 0, 0, ld, lv);
    chk("split2_ld", ld, 2);
    chk("split2_fired", fired, 1);
    chk("split2_count", count, 2);

    // A packet with enable=0 leaves fired clear, count unchanged and the context untouched.
    send_pkt(5, 0, 32'h616263, 3, 0, 0, 0, ld, lv);
    chk("dis_ld", ld, 3);
    chk("dis_fired", fired, 0);
    chk("dis_count", count, 2);
    send_pkt(5, 1, 32'h6162, 2, 0, 0, 0, ld, lv);
    chk("dis_keep_state", ld, 3);
    send_pkt(7, 0, 32'h616263, 3, 0, 0, 0, ld, lv);
    chk("s7_dis_ld", ld, 0);
    send_pkt(7, 1, 32'h78, 1, 0, 0, 0, ld, lv);
    chk("s7_still_invalid", ld, 0);
    chk("s7_count", count, 2);

    // Flush in IDLE is honoured; a flush while busy is ignored.
    stream_id    = 5;
    flush_stream = 1'b1;
    tick;
    flush_stream = 1'b0;
    send_pkt(5, 1, 32'h78, 1, 0, 0, 0, ld, lv);
    chk("flush_idle_ld", ld, 0);
    send_pkt(9, 1, 32'h61, 1, 1, 0, 0, ld, lv);
    chk("s9_ld1", ld, 1);
    send_pkt(9, 1, 32'h78, 1, 0, 0, 0, ld, lv);
    chk("flush_busy_ignored", ld, 1);
    chk("perr_clean", proto_err, 0);

    // Saturation with COUNT_W=4.
    count_clr = 1'b1;
    tick;
    count_clr = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_sat", count_sat, 0);
    for (int i = 1; i <= 17; i++) begin
      send_pkt(10, 1, 32'h616263, 3, 0, 0, 0, ld, lv);
      if (i == 14) begin
        chk("cnt14", count, 14);
        chk("sat14", count_sat, 0);
      end
      if (i == 15) begin
        chk("cnt15", count, 15);
        chk("sat15", count_sat, 1);
      end
    end
    chk("cnt17", count, 15);
    chk("sat17", count_sat, 1);
    send_pkt(10, 1, 32'h616263, 3, 0, 0, 1, ld, lv);
    chk("clr_commit_count", count, 0);
    chk("clr_commit_sat", count_sat, 0);
    chk("clr_commit_fired", fired, 1);

    // Reset during RUN aborts the packet.
    send_pkt(11, 1, 32'h616263, 3, 0, 0, 0, ld, lv);
    chk("s11_count", count, 1);
    stream_id = 11; enable = 1'b1; pkt_start = 1'b1;
    tick;
    pkt_start = 1'b0;
    tick;
    char_in = 8'h61; char_in_vld = 1'b1;
    tick;
    char_in = 8'h62;
    tick;
    rst = 1'b1;
    char_in_vld = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    tick;
    rst = 1'b0;
    repeat (5) tick;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_perr", proto_err, 0);
    send_pkt(11, 1, 32'h78, 1, 0, 0, 0, ld, lv);
    chk("post_rst_ld", ld, 0);
    chk("post_rst_count2", count, 0);

    // Stray pkt_start during DRAIN.
    send_pkt(12, 1, 32'h616263, 3, 0, 1, 0, ld, lv);
    chk("stray_perr", proto_err, 1);
    chk("stray_fired", fired, 1);
    chk("stray_count", count, 1);

    // A byte while IDLE is a protocol error.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("perr_cleared", proto_err, 0);
    char_in_vld = 1'b1;
    tick;
    char_in_vld = 1'b0;
    chk("idle_byte_perr", proto_err, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/regex_stream_ctx.md
REGEX_STREAM_CTX -- requirements
Module: regex_stream_ctx

Interface
REQ-001 Parameter STATE_W, default 11: DFA state width.
REQ-002 Parameter SID_W, default 6: stream-id width; context depth is 2**SID_W.
REQ-003 Parameter COUNT_W, default 16: match-count width.
REQ-004 Parameter DFA_LAT, default 1: cycles from dfa_char_vld to valid dfa_state_out/dfa_accept; range 1-4.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 pkt_start  in  1  one-cycle pulse, start of packet; samples stream_id, enable.
REQ-009 stream_id  in  SID_W  packet stream id; also flush target.
REQ-010 enable  in  1  regex enabled for this packet.
REQ-011 char_in  in  8  payload byte.
REQ-012 char_in_vld  in  1  char_in valid.
REQ-013 eop  in  1  end of packet; coincident with or after last char_in_vld.
REQ-014 flush_stream  in  1  invalidate context of stream_id.
REQ-015 count_clr  in  1  synchronous clear of count and count_sat.
REQ-016 dfa_char  out  8  registered byte to DFA.
REQ-017 dfa_char_vld  out  1  registered char valid to DFA.
REQ-018 dfa_state_in  out  STATE_W  state to load into DFA.
REQ-019 dfa_state_in_vld  out  1  one-cycle state-load strobe.
REQ-020 dfa_state_out  in  STATE_W  DFA current state.
REQ-021 dfa_accept  in  1  DFA accept flag.
REQ-022 count  out  COUNT_W  saturating count of matched enabled packets.
REQ-023 count_sat  out  1  sticky: count reached all-ones.
REQ-024 fired  out  1  current/last packet matched.
REQ-025 busy  out  1  FSM not in IDLE.
REQ-026 proto_err  out  1  sticky protocol violation flag; cleared only by rst.

Function
REQ-027 FSM states IDLE, LOAD, RUN, DRAIN, COMMIT; busy=1 outside IDLE.
REQ-028 IDLE: pkt_start -> LOAD; latch stream_id as cur_sid, enable as cur_en; clear fired.
REQ-029 LOAD (one cycle): drive dfa_state_in_vld=1 with dfa_state_in = state_mem[cur_sid] if valid[cur_sid], else 0; -> RUN.
REQ-030 RUN: dfa_char/dfa_char_vld = char_in/char_in_vld delayed one cycle; eop -> DRAIN.
REQ-031 DRAIN lasts DFA_LAT+1 cycles so the last byte's result is registered; then -> COMMIT.
REQ-032 dfa_state_out and dfa_accept are registered internally; fired sets on registered accept in RUN or DRAIN and holds.
REQ-033 COMMIT (one cycle), cur_en=1: state_mem[cur_sid] <= registered state; valid[cur_sid] <= 1; count <= count+fired, saturating.
REQ-034 COMMIT, cur_en=0: no state write, valid unchanged, count unchanged, fired cleared.
REQ-035 COMMIT -> IDLE; pkt_start in that same cycle is ignored and sets proto_err.
REQ-036 Saturation: count held at 2**COUNT_W-1; count_sat set when count reaches that value.
REQ-037 count_clr beats a same-cycle increment: count=0, count_sat=0, increment dropped.
REQ-038 flush_stream honored only in IDLE without pkt_start: valid[stream_id] <= 0; otherwise ignored.
REQ-039 pkt_start outside IDLE, or char_in_vld in IDLE/DRAIN/COMMIT, is ignored and sets proto_err.
REQ-040 eop with char_in_vld in RUN: that byte is processed before commit.
REQ-041 dfa_char_vld=0 outside RUN, except the delayed final eop byte.

Reset
REQ-042 rst async: FSM IDLE; all valid bits 0; count, count_sat, fired, busy, proto_err, dfa_char_vld, dfa_state_in_vld = 0.
REQ-043 state_mem not reset; valid bits guard it.
REQ-044 rst mid-packet aborts the packet: no commit, no count change after release.

Verification
REQ-045 New stream 5, enable=1, bytes matching, eop -> LOAD state_in=0, fired=1, count 0->1, valid[5]=1.
REQ-046 Split match: stream 5 packet 1 ends mid-pattern, stream 9 packet, stream 5 packet 2 completes pattern -> stream 5 restored state used, fired=1 only on packet 2.
REQ-047 enable=0 matching packet -> fired cleared at COMMIT, count unchanged, valid[sid] unchanged.
REQ-048 COUNT_W=4, 17 matching packets -> count=15, count_sat=1; count_clr during COMMIT -> count=0, count_sat=0.
REQ-049 flush_stream sid 5 in IDLE, then new packet sid 5 -> dfa_state_in=0; flush while busy -> ignored.
REQ-050 rst during RUN, pkt_start during DRAIN -> no commit after rst; proto_err=1 for stray pkt_start.
